// File: rtl/ram_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// tpu_ram_arb_pkg
//
// Shared definitions for the scratchpad RAM port arbiters.
//   - Arbiter state encoding (IDLE / LOCKED).
//   - Default requester count and burst-lock limit.
//   - clog2_min1: ceiling log2 clamped to at least 1, used to size index and
//     burst-counter registers so that a single-entry case still has a bit.
//
// The RAM geometry defines normally come from the RAM wrapper; fallbacks are
// provided so this slice elaborates on its own.
// -----------------------------------------------------------------------------
`ifndef AWIDTH
`define AWIDTH 10
`endif
`ifndef DWIDTH
`define DWIDTH 8
`endif
`ifndef MASK_WIDTH
`define MASK_WIDTH 4
`endif

package tpu_ram_arb_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  localparam int NUM_REQ_DEF   = 3;
  localparam int MAX_BURST_DEF = 16;

  function automatic int clog2_min1(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) begin
      w = w + 1;
    end
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/ram_port_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
//
// Combinational round-robin picker. Scans req_i starting at ptr_i and wrapping
// modulo N; the first asserted request wins. When excl_en_i is set the entry
// at excl_idx_i is skipped even if it is requesting.
//
// Ports:
//   req_i       in  N   request vector
//   ptr_i       in  IW  index with highest priority for this pick
//   excl_en_i   in  1   enable exclusion of excl_idx_i
//   excl_idx_i  in  IW  index to skip when excl_en_i=1
//   gnt_o       out N   one-hot winner (zero when nothing eligible)
//   idx_o       out IW  binary index of the winner (0 when none)
//   any_o       out 1   a winner exists
// -----------------------------------------------------------------------------
module rr_pick #(
  parameter int N  = 3,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  input  logic          excl_en_i,
  input  logic [IW-1:0] excl_idx_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  always_comb begin
    logic found;
    int   j;
    found = 1'b0;
    j     = 0;
    gnt_o = '0;
    idx_o = '0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr_i) + k) % N;
      if (!found && req_i[j] && !(excl_en_i && (excl_idx_i == IW'(j)))) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IW'(j);
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// -----------------------------------------------------------------------------
// ram_port_arbiter
//
// Shares one addr/d/we/q port of the scratchpad RAM between NUM_REQ requesters
// (operand fetch, writeback, host/DMA load). Grants are combinational and
// round-robin; a requester may hold the port across consecutive beats with
// req_lock, bounded by MAX_BURST beats whenever someone else is waiting.
// Read data returns one cycle after the read beat with a one-hot valid that
// identifies the requester that issued it.
//
// Ports:
//   clk        in   1           clock
//   resetn     in   1           synchronous active-low reset
//   req        in   NUM_REQ     per-requester access request
//   req_lock   in   NUM_REQ     hold grant across consecutive beats
//   req_addr   in   NUM_REQ*AW  addresses, requester i at [i*AW +: AW]
//   req_wdata  in   NUM_REQ*DW  write data, requester i at [i*DW +: DW]
//   req_we     in   NUM_REQ*MW  byte write masks; all-zero means read
//   gnt        out  NUM_REQ     one-hot (or zero) grant
//   rsp_valid  out  NUM_REQ     one-hot read-response valid
//   rsp_data   out  DW          RAM read data, broadcast
//   ram_addr   out  AW          RAM port address
//   ram_d      out  DW          RAM port write data
//   ram_we     out  MW          RAM port byte write enables
//   ram_q      in   DW          RAM port read data (1-cycle latency)
// -----------------------------------------------------------------------------
module ram_port_arbiter
  import tpu_ram_arb_pkg::*;
#(
  parameter int NUM_REQ   = NUM_REQ_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF,
  parameter int AW        = `AWIDTH,
  parameter int DW        = `MASK_WIDTH * `DWIDTH,
  parameter int MW        = `MASK_WIDTH
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ-1:0]    req_lock,
  input  logic [NUM_REQ*AW-1:0] req_addr,
  input  logic [NUM_REQ*DW-1:0] req_wdata,
  input  logic [NUM_REQ*MW-1:0] req_we,
  output logic [NUM_REQ-1:0]    gnt,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [DW-1:0]         rsp_data,
  output logic [AW-1:0]         ram_addr,
  output logic [DW-1:0]         ram_d,
  output logic [MW-1:0]         ram_we,
  input  logic [DW-1:0]         ram_q
);

  localparam int IW = clog2_min1(NUM_REQ);
  localparam int CW = clog2_min1(MAX_BURST) + 1;

  localparam logic [CW-1:0] BURST_MAX = CW'(MAX_BURST);
  localparam logic [CW-1:0] BURST_ONE = CW'(1);

  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] idx);
    if (int'(idx) >= NUM_REQ - 1) begin
      return '0;
    end
    return idx + IW'(1);
  endfunction

  // Registered control state
  arb_state_e           state_q, state_d;
  logic [IW-1:0]        owner_q, owner_d;
  logic [IW-1:0]        prio_q, prio_d;
  logic [CW-1:0]        burst_cnt_q, burst_cnt_d;
  logic [NUM_REQ-1:0]   rd_pend_q, rd_pend_d;

  // Lock-holder status
  logic [NUM_REQ-1:0]   owner_oh;
  logic                 owner_req;
  logic                 owner_lock;
  logic                 others_pend;
  logic                 at_cap;
  logic                 force_rel;
  logic                 hold_lock;

  // Picker interface
  logic [IW-1:0]        pick_ptr;
  logic [NUM_REQ-1:0]   pick_gnt;
  logic [IW-1:0]        pick_idx;
  logic                 pick_any;

  // Resolved grant for this cycle (before reset gating)
  logic [NUM_REQ-1:0]   gnt_c;
  logic [IW-1:0]        gnt_idx;
  logic                 gnt_any;

  assign owner_oh    = NUM_REQ'(1) << owner_q;
  assign owner_req   = req[owner_q];
  assign owner_lock  = req_lock[owner_q];
  assign others_pend = |(req & ~owner_oh);
  assign at_cap      = (burst_cnt_q == BURST_MAX);

  // The owner still wants the port but has used its burst budget while
  // somebody else waits: hand the port to the next requester after the owner.
  assign force_rel = (state_q == ARB_LOCKED) && owner_req && owner_lock &&
                     at_cap && others_pend;
  assign hold_lock = (state_q == ARB_LOCKED) && owner_req && owner_lock &&
                     !force_rel;

  // A forced release scans from the slot after the owner and skips the owner;
  // otherwise plain round-robin from the priority pointer.
  assign pick_ptr = force_rel ? wrap_inc(owner_q) : prio_q;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .req_i      (req),
    .ptr_i      (pick_ptr),
    .excl_en_i  (force_rel),
    .excl_idx_i (owner_q),
    .gnt_o      (pick_gnt),
    .idx_o      (pick_idx),
    .any_o      (pick_any)
  );

  // Next-state / grant selection
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    prio_d      = prio_q;
    burst_cnt_d = burst_cnt_q;
    gnt_c       = '0;
    gnt_idx     = '0;
    gnt_any     = 1'b0;

    if (hold_lock) begin
      gnt_c   = owner_oh;
      gnt_idx = owner_q;
      gnt_any = 1'b1;
      // With nobody else waiting the budget simply restarts.
      burst_cnt_d = at_cap ? BURST_ONE : (burst_cnt_q + BURST_ONE);
    end else begin
      // Unlocked arbitration; also covers the cycle a lock ends, so the
      // release costs no bubble.
      state_d     = ARB_IDLE;
      burst_cnt_d = '0;
      gnt_c       = pick_gnt;
      gnt_idx     = pick_idx;
      gnt_any     = pick_any;
      if (pick_any) begin
        if (req_lock[pick_idx]) begin
          state_d     = ARB_LOCKED;
          owner_d     = pick_idx;
          burst_cnt_d = BURST_ONE;
        end else begin
          prio_d = wrap_inc(pick_idx);
        end
      end
    end
  end

  // A read beat is a granted beat whose byte mask is all zero.
  always_comb begin
    rd_pend_d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rd_pend_d[i] = gnt_c[i] & req[i] & (req_we[i*MW +: MW] == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= ARB_IDLE;
      owner_q     <= '0;
      prio_q      <= '0;
      burst_cnt_q <= '0;
      rd_pend_q   <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      prio_q      <= prio_d;
      burst_cnt_q <= burst_cnt_d;
      rd_pend_q   <= rd_pend_d;
    end
  end

  // Outputs are forced quiet while reset is held, including a response that
  // was in flight when reset arrived.
  assign gnt       = resetn ? gnt_c : '0;
  assign rsp_valid = resetn ? rd_pend_q : '0;
  assign rsp_data  = ram_q;

  always_comb begin
    ram_addr = '0;
    ram_d    = '0;
    ram_we   = '0;
    if (resetn && gnt_any) begin
      ram_addr = req_addr[int'(gnt_idx)*AW +: AW];
      ram_d    = req_wdata[int'(gnt_idx)*DW +: DW];
      ram_we   = req_we[int'(gnt_idx)*MW +: MW];
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
module tb_ram_port_arbiter;

  localparam int NR = 3;
  localparam int AW = `AWIDTH;
  localparam int DW = `MASK_WIDTH * `DWIDTH;
  localparam int MW = `MASK_WIDTH;
  localparam int BW = DW / MW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                resetn;
  logic [NR-1:0]       req, req_lock;
  logic [NR*AW-1:0]    req_addr;
  logic [NR*DW-1:0]    req_wdata;
  logic [NR*MW-1:0]    req_we;
  logic [NR-1:0]       gnt, rsp_valid;
  logic [DW-1:0]       rsp_data, ram_d, ram_q;
  logic [AW-1:0]       ram_addr;
  logic [MW-1:0]       ram_we;

  // Per-requester fields as applied to the DUT, and staged next values
  logic [AW-1:0] a[NR], a_n[NR];
  logic [DW-1:0] wd[NR], wd_n[NR];
  logic [MW-1:0] we[NR], we_n[NR];

  always_comb begin
    for (int i = 0; i < NR; i++) begin
      req_addr[i*AW +: AW]  = a[i];
      req_wdata[i*DW +: DW] = wd[i];
      req_we[i*MW +: MW]    = we[i];
    end
  end

  ram_port_arbiter dut (
    .clk       (clk),
    .resetn    (resetn),
    .req       (req),
    .req_lock  (req_lock),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_we    (req_we),
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .ram_addr  (ram_addr),
    .ram_d     (ram_d),
    .ram_we    (ram_we),
    .ram_q     (ram_q)
  );

  // RAM port model: byte-masked write, registered read-before-write
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    for (int b = 0; b < MW; b++) begin
      if (ram_we[b]) mem[ram_addr][b*BW +: BW] <= ram_d[b*BW +: BW];
    end
    ram_q <= mem[ram_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [NR-1:0] gnt;
    logic [AW-1:0] addr;
    logic [DW-1:0] d;
    logic [MW-1:0] we;
  } drv_t;

  typedef struct {
    int            cyc;
    logic [NR-1:0] vld;
    logic [DW-1:0] data;
  } rsp_t;

  drv_t drv_q[$];
  rsp_t rsp_q[$];

  int nvec  = 0;
  int nfail = 0;
  bit done  = 1'b0;
  bit wrote10 = 1'b0;

  // Expected RAM contents: preload pattern, except the word written in test
  function automatic logic [DW-1:0] exp_word(input logic [AW-1:0] ad);
    if (wrote10 && ad == AW'(16)) return 32'hA1B2C3D4;
    return 32'hC0DE0000 | DW'(ad);
  endfunction

  // One clock of stimulus with the grant expected for that cycle
  task automatic beat(input logic rn, input logic [NR-1:0] r,
                      input logic [NR-1:0] l, input logic [NR-1:0] eg);
    drv_t dv;
    rsp_t rv;
    int   gi;
    @(posedge clk);
    #1;
    resetn   = rn;
    req      = r;
    req_lock = l;
    for (int i = 0; i < NR; i++) begin
      a[i] = a_n[i]; wd[i] = wd_n[i]; we[i] = we_n[i];
    end
    // Reset this cycle swallows the response due now
    if (!rn) begin
      while (rsp_q.size() > 0 && rsp_q[rsp_q.size()-1].cyc == cyc)
        void'(rsp_q.pop_back());
    end
    gi = -1;
    for (int i = 0; i < NR; i++) if (eg[i]) gi = i;
    dv.gnt = eg; dv.addr = '0; dv.d = '0; dv.we = '0;
    if (gi >= 0) begin
      dv.addr = a[gi]; dv.d = wd[gi]; dv.we = we[gi];
      if (we[gi] == '0) begin
        rv.cyc  = cyc + 1;
        rv.vld  = eg;
        rv.data = exp_word(a[gi]);
        rsp_q.push_back(rv);
      end
    end
    drv_q.push_back(dv);
  endtask

  // Monitor / scoreboard
  initial begin
    drv_t e;
    rsp_t r;
    bit   fin;
    fin = 1'b0;
    forever begin
      @(negedge clk);
      if (drv_q.size() > 0) begin
        e = drv_q.pop_front();
        nvec++;
        if (gnt !== e.gnt || ram_addr !== e.addr || ram_d !== e.d || ram_we !== e.we) begin
          nfail++;
          $display("FAIL drive cyc=%0d: got gnt=%b addr=%h d=%h we=%h, want gnt=%b addr=%h d=%h we=%h",
                   cyc, gnt, ram_addr, ram_d, ram_we, e.gnt, e.addr, e.d, e.we);
        end
      end
      while (rsp_q.size() > 0 && rsp_q[0].cyc < cyc) begin
        r = rsp_q.pop_front();
        nvec++; nfail++;
        $display("FAIL rsp_missing cyc=%0d: expected vld=%b data=%h at cyc %0d", cyc, r.vld, r.data, r.cyc);
      end
      if (rsp_q.size() > 0 && rsp_q[0].cyc == cyc) begin
        r = rsp_q.pop_front();
        nvec++;
        if (rsp_valid !== r.vld || rsp_data !== r.data) begin
          nfail++;
          $display("FAIL rsp cyc=%0d: got vld=%b data=%h, want vld=%b data=%h",
                   cyc, rsp_valid, rsp_data, r.vld, r.data);
        end
      end else if (rsp_valid !== '0) begin
        nvec++; nfail++;
        $display("FAIL rsp_unexpected cyc=%0d: got vld=%b, want 000", cyc, rsp_valid);
      end
      if (done && !fin) begin
        fin = 1'b1;
        nvec++;
        if (rsp_q.size() != 0 || drv_q.size() != 0) begin
          nfail++;
          $display("FAIL drain: %0d responses and %0d drives left, want 0 and 0", rsp_q.size(), drv_q.size());
        end
      end
    end
  end

  // Stimulus
  initial begin
    resetn = 1'b0; req = '0; req_lock = '0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = 32'hC0DE0000 | DW'(i);
    a_n[0] = 10'h020; a_n[1] = 10'h041; a_n[2] = 10'h062;
    wd_n[0] = 32'h0D0D0000; wd_n[1] = 32'h1D1D0001; wd_n[2] = 32'h2D2D0002;
    for (int i = 0; i < NR; i++) begin
      we_n[i] = '0; a[i] = a_n[i]; wd[i] = wd_n[i]; we[i] = '0;
    end

    // Reset held with all requesting: nothing granted, RAM port quiet
    repeat (3) beat(1'b0, 3'b111, 3'b000, 3'b000);

    // Round-robin reads after release
    beat(1'b1, 3'b111, 3'b000, 3'b001);
    beat(1'b1, 3'b111, 3'b000, 3'b010);
    beat(1'b1, 3'b111, 3'b000, 3'b100);
    beat(1'b1, 3'b111, 3'b000, 3'b001);
    beat(1'b1, 3'b111, 3'b000, 3'b010);
    beat(1'b1, 3'b111, 3'b000, 3'b100);
    beat(1'b1, 3'b000, 3'b000, 3'b000);

    // Write then read back the same word
    a_n[0] = 10'h010; wd_n[0] = 32'hA1B2C3D4; we_n[0] = 4'hF;
    beat(1'b1, 3'b001, 3'b000, 3'b001);
    wrote10 = 1'b1;
    we_n[0] = 4'h0;
    beat(1'b1, 3'b001, 3'b000, 3'b001);

    // Requester 2 alone moves the priority pointer back to 0
    beat(1'b1, 3'b100, 3'b000, 3'b100);

    // Burst cap: 16 locked beats for 0, then 1 gets beat 17
    a_n[0] = 10'h030;
    repeat (16) beat(1'b1, 3'b011, 3'b001, 3'b001);
    beat(1'b1, 3'b011, 3'b001, 3'b010);
    beat(1'b1, 3'b001, 3'b001, 3'b001);
    beat(1'b1, 3'b000, 3'b000, 3'b000);

    // Uncontended lock runs past the cap; dropping the lock re-arbitrates
    repeat (40) beat(1'b1, 3'b001, 3'b001, 3'b001);
    beat(1'b1, 3'b101, 3'b000, 3'b100);
    beat(1'b1, 3'b000, 3'b000, 3'b000);

    // Reset on beat 5 of a locked read burst
    repeat (4) beat(1'b1, 3'b001, 3'b001, 3'b001);
    beat(1'b0, 3'b001, 3'b001, 3'b000);
    beat(1'b1, 3'b110, 3'b000, 3'b010);
    beat(1'b1, 3'b110, 3'b000, 3'b100);
    beat(1'b1, 3'b000, 3'b000, 3'b000);
    beat(1'b1, 3'b000, 3'b000, 3'b000);

    done = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares one port of the dual-port scratchpad RAM between NUM_REQ requesters, e.g. systolic operand fetch, output writeback and host/DMA load.
- Round-robin arbitration with an optional bounded burst lock.
- Drives the RAM port address, data and byte-write-mask; returns RAM read data with a one-hot valid to the requester that issued the read.
- Sits between the requesters and one addr/d/we/q port of the RAM wrapper.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- MAX_BURST, 16, maximum consecutive locked beats while another requester is pending.
- AW, `AWIDTH, address width.
- DW, `MASK_WIDTH*`DWIDTH, data width.
- MW, `MASK_WIDTH, byte write-mask width.

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous active-low reset.
- req  in  NUM_REQ  per-requester access request.
- req_lock  in  NUM_REQ  holds the grant across consecutive beats.
- req_addr  in  NUM_REQ*AW  flattened addresses, requester i at [i*AW +: AW].
- req_wdata  in  NUM_REQ*DW  flattened write data.
- req_we  in  NUM_REQ*MW  flattened byte write masks; all-zero means read.
- gnt  out  NUM_REQ  one-hot (or zero) grant; a beat completes when req[i]&gnt[i].
- rsp_valid  out  NUM_REQ  one-hot read-response valid.
- rsp_data  out  DW  RAM read data, broadcast to all requesters.
- ram_addr  out  AW  to RAM port address.
- ram_d  out  DW  to RAM port write data.
- ram_we  out  MW  to RAM port byte write enables.
- ram_q  in  DW  from RAM port read data (registered inside the RAM, 1-cycle latency).

Behaviour:
- Registered state:
  - prio_ptr: index of the highest-priority requester.
  - owner, owner_vld: current lock holder.
  - burst_cnt: log2(MAX_BURST)+1 bits.
  - rd_pend: NUM_REQ bits.
- Reset (resetn=0 at posedge) sets prio_ptr=0, owner_vld=0, burst_cnt=0, rd_pend=0.
- While resetn=0: gnt=0, ram_we=0, ram_addr=0, ram_d=0, rsp_valid=0, regardless of req.
- FSM states:
  - IDLE (owner_vld=0): gnt selects the first asserted req scanning prio_ptr, prio_ptr+1, ... mod NUM_REQ. Combinational, zero-latency grant.
  - LOCKED (owner_vld=1): gnt=owner if req[owner]=1.
- Transitions:
  - IDLE->LOCKED when the granted requester i has req_lock[i]=1. Set owner=i, burst_cnt=1.
  - LOCKED stays LOCKED while req[owner]&req_lock[owner]; burst_cnt increments per beat.
  - LOCKED->IDLE when req[owner]=0 or req_lock[owner]=0. That cycle is arbitrated as IDLE, so no bubble.
  - LOCKED->IDLE forced when burst_cnt==MAX_BURST and any other req is asserted. That cycle grants the next requester in round-robin order, never the owner.
  - If burst_cnt==MAX_BURST and no other req is pending, burst_cnt resets to 1 and the lock continues.
- prio_ptr update: on every granted beat that ends or has no lock, prio_ptr = (granted index + 1) mod NUM_REQ. Unchanged when nothing is granted.
- RAM drive:
  - ram_addr/ram_d = granted requester's fields.
  - ram_we = granted requester's mask.
  - With no grant, all three are 0.
- Read return:
  - rd_pend[i] <= gnt[i] & req[i] & (req_we slice i == 0).
  - rsp_valid = rd_pend; rsp_data = ram_q. Valid exactly 1 cycle after the read beat.
  - Write beats never produce rsp_valid.
- Back-to-back reads by different requesters give one response per cycle, in grant order.
- Reset asserted mid-burst clears the lock and drops any in-flight response; no rsp_valid in the cycle after reset.
- Requester contract: req_addr/wdata/we are stable while req=1 and gnt=0. The arbiter does not check this.

Decomposition:
- Shared package (tpu_ram_arb_pkg):
  - state encoding ARB_IDLE=1'b0, ARB_LOCKED=1'b1.
  - NUM_REQ and MAX_BURST defaults.
  - log2 helper for the counter and index widths.
- Widths come from the existing `AWIDTH/`DWIDTH/`MASK_WIDTH defines.
- One sub-module: rr_pick, a combinational one-hot picker with inputs (req vector, prio_ptr, exclude-index enable) and outputs (one-hot gnt, binary index). Reused by future arbiters.

Test Plan:
- Reset: hold resetn=0 with req=3'b111 -> gnt=0, ram_we=0, rsp_valid=0. Release; first cycle with req=3'b111 -> gnt=3'b001.
- Round-robin: req=3'b111, no lock, all reads, 6 cycles -> gnt sequence 001,010,100,001,010,100. rsp_valid follows one cycle later with matching ram_q data.
- Write then read: req0 write addr 0x10, wdata 0xA1B2C3D4, we=4'hF; next cycle req0 read 0x10 -> rsp_valid=3'b001 one cycle after the read, rsp_data=0xA1B2C3D4. No rsp_valid for the write beat.
- Burst cap: req0 locked continuously, req1 asserted from cycle 0, MAX_BURST=16 -> gnt0 for 16 beats, gnt1 on beat 17, then gnt0 again once req1 drops.
- Lock with no contention: req0 locked for 40 beats, others idle -> gnt0 for all 40 beats with no bubble. Drop req_lock -> same cycle is arbitrated as IDLE.
- Mid-burst reset: reset asserted on beat 5 of a locked read burst -> the next cycle has rsp_valid=0 and owner cleared. After release, req=3'b110 -> gnt=3'b010.
